// File: rtl/icb_csr_bank.sv
// ICB slave register bank: CTRL/STATUS/ID plus NUM_CFG byte-maskable config registers.
// Drives the accelerator start pulse, tracks busy/done and raises a level interrupt.
module icb_csr_bank #(
    parameter int unsigned NUM_CFG  = 8,
    parameter int unsigned ADDR_W   = 12,
    parameter logic [31:0] ID_VALUE = 32'hACC0_0002
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  icb_cmd_valid,
    output logic                  icb_cmd_ready,
    input  logic                  icb_cmd_read,
    input  logic [31:0]           icb_cmd_addr,
    input  logic [31:0]           icb_cmd_wdata,
    input  logic [3:0]            icb_cmd_wmask,
    output logic                  icb_rsp_valid,
    input  logic                  icb_rsp_ready,
    output logic [31:0]           icb_rsp_rdata,
    output logic                  icb_rsp_err,
    output logic [NUM_CFG*32-1:0] cfg,
    output logic                  start,
    output logic                  busy,
    output logic                  irq,
    input  logic                  acc_done
);

    localparam logic [ADDR_W-1:0] OffCtrl   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] OffStatus = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] OffId     = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] OffCfg    = ADDR_W'(12);

    logic              rsp_valid_q, rsp_err_q, start_q, busy_q, done_q, irq_en_q, irq_q;
    logic [31:0]       rsp_rdata_q;

    logic              cmd_fire;
    logic [ADDR_W-1:0] offset, cfg_off;
    logic [ADDR_W-3:0] cfg_word;
    logic              aligned, is_ctrl, is_status, is_id, is_cfg, map_err;
    logic [NUM_CFG-1:0] cfg_sel;
    logic [31:0]       byte_mask, rd_data;
    logic              wr_ok, ctrl_wr, start_req, start_fire, start_err, done_clr, done_set;
    logic              unused_addr;

    assign icb_cmd_ready = ~rsp_valid_q | icb_rsp_ready;
    assign cmd_fire      = icb_cmd_valid & icb_cmd_ready;
    assign unused_addr   = ^{icb_cmd_addr[31:ADDR_W], cfg_off[1:0]};

    always_comb begin
        offset    = icb_cmd_addr[ADDR_W-1:0];
        cfg_off   = offset - OffCfg;
        cfg_word  = cfg_off[ADDR_W-1:2];
        aligned   = (offset[1:0] == 2'b00);
        is_ctrl   = (offset == OffCtrl);
        is_status = (offset == OffStatus);
        is_id     = (offset == OffId);
        cfg_sel   = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            cfg_sel[i] = (offset >= OffCfg) && (cfg_word == (ADDR_W-2)'(i));
        end
        is_cfg    = |cfg_sel;
        map_err   = ~aligned | ~(is_ctrl | is_status | is_id | is_cfg);
        byte_mask = {{8{icb_cmd_wmask[3]}}, {8{icb_cmd_wmask[2]}},
                     {8{icb_cmd_wmask[1]}}, {8{icb_cmd_wmask[0]}}};
    end

    always_comb begin
        wr_ok      = cmd_fire & ~icb_cmd_read & ~map_err;
        ctrl_wr    = wr_ok & is_ctrl & icb_cmd_wmask[0];
        start_req  = ctrl_wr & icb_cmd_wdata[0];
        start_fire = start_req & ~busy_q;
        // A refused START still lets the IRQ_EN bit in the same byte through.
        start_err  = start_req & busy_q;
        done_clr   = wr_ok & is_status & icb_cmd_wmask[0] & icb_cmd_wdata[0];
        done_set   = acc_done & busy_q;
    end

    always_comb begin
        rd_data = '0;
        if (is_ctrl) begin
            rd_data = {30'b0, irq_en_q, 1'b0};
        end else if (is_status) begin
            rd_data = {30'b0, busy_q, done_q};
        end else if (is_id) begin
            rd_data = ID_VALUE;
        end else begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (cfg_sel[i]) begin
                    rd_data = cfg[32*i +: 32];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CFG; g++) begin : gen_cfg
        logic [31:0] cfg_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                cfg_q <= '0;
            end else if (wr_ok && cfg_sel[g]) begin
                cfg_q <= (cfg_q & ~byte_mask) | (icb_cmd_wdata & byte_mask);
            end
        end
        assign cfg[32*g +: 32] = cfg_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (cmd_fire) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= (icb_cmd_read && !map_err) ? rd_data : 32'h0;
                rsp_err_q   <= map_err | start_err;
            end else if (icb_rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            if (ctrl_wr) begin
                irq_en_q <= icb_cmd_wdata[1];
            end
            start_q <= start_fire;
            if (done_set) begin
                busy_q <= 1'b0;
            end else if (start_fire) begin
                busy_q <= 1'b1;
            end
            // Completion wins over a simultaneous write-1-to-clear.
            if (done_set) begin
                done_q <= 1'b1;
            end else if (done_clr) begin
                done_q <= 1'b0;
            end
            irq_q <= done_q & irq_en_q;
        end
    end

    assign icb_rsp_valid = rsp_valid_q;
    assign icb_rsp_rdata = rsp_rdata_q;
    assign icb_rsp_err   = rsp_err_q;
    assign start         = start_q;
    assign busy          = busy_q;
    assign irq           = irq_q;

endmodule

// File: doc/icb_csr_bank.md
Name: icb_csr_bank

Overview:
- Parametrised ICB slave register bank for the accelerator: NUM_CFG generic 32-bit configuration registers, plus CTRL, STATUS and ID registers.
- Adds features the first-generation slave lacks: byte-mask writes, self-clearing start pulse, busy tracking, W1C done flag, interrupt output and error responses.
- Sits between the core's ICB bus and the main FSM; exports a flat config bus, start pulse and irq.

Parameters:
- NUM_CFG, 8, number of 32-bit config registers (1..32)
- ADDR_W, 12, number of low address bits decoded; higher bits ignored
- ID_VALUE, 32'hACC0_0002, read-only value of ID register

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- icb_cmd_valid  in  1  command valid
- icb_cmd_ready  out  1  command ready (combinational)
- icb_cmd_read  in  1  1 = read, 0 = write
- icb_cmd_addr  in  32  byte address
- icb_cmd_wdata  in  32  write data
- icb_cmd_wmask  in  4  byte enables; bit k enables wdata[8k+7:8k]
- icb_rsp_valid  out  1  response valid (registered)
- icb_rsp_ready  in  1  response accepted
- icb_rsp_rdata  out  32  read data; 0 for writes and errors
- icb_rsp_err  out  1  error flag, qualified by rsp_valid
- cfg  out  NUM_CFG*32  config registers; CFG[i] at bits [32i+31:32i]
- start  out  1  one-cycle start pulse to main FSM
- busy  out  1  accelerator running
- irq  out  1  interrupt, level
- acc_done  in  1  one-cycle completion pulse from main FSM

Behaviour:
- Transfer and reset:
  - Transfer fires when icb_cmd_valid & icb_cmd_ready.
  - Only addr[ADDR_W-1:0] is decoded.
  - Reset: all registers, cfg, start, busy, irq, icb_rsp_valid, icb_rsp_rdata and icb_rsp_err are 0.
- Register map (offsets):
  - 0x00 CTRL: bit0 START (write-1 action, reads 0); bit1 IRQ_EN (RW).
  - 0x04 STATUS: bit0 DONE (W1C); bit1 BUSY (RO).
  - 0x08 ID: RO, reads ID_VALUE.
  - 0x0C+4*i: CFG[i], RW, for i < NUM_CFG.
- Errors:
  - Error when offset is not in the map, or addr[1:0] != 0.
  - Error response: err = 1, rdata = 0, no state change.
  - Writes to ID or to STATUS bit1 are silently ignored; err = 0.
- Writes:
  - Each byte lane is updated only if its wmask bit is set.
  - START and DONE actions need wmask[0] = 1.
  - wmask = 0 performs no update and returns err = 0.
- Handshake:
  - icb_cmd_ready = ~icb_rsp_valid | icb_rsp_ready; at most one outstanding response.
  - Command fired in cycle N gives rsp_valid high in N+1, with rdata/err registered from state before any same-cycle update.
  - Response is held stable until rsp_valid & rsp_ready.
  - With rsp_ready held at 1, back-to-back commands complete one per cycle.
  - rsp_valid clears when the response is accepted and no new command fires that cycle.
- Start and busy:
  - Writing CTRL with START = 1 while busy = 0 makes start = 1 for exactly the next cycle; busy = 1 from that same cycle.
  - START = 1 while busy = 1: ignored, response err = 1; the IRQ_EN byte write still applies.
  - busy clears the cycle after acc_done.
  - acc_done while busy = 0 is ignored.
- DONE:
  - DONE sets the cycle after acc_done (when busy).
  - A W1C of DONE in the same cycle as acc_done leaves DONE = 1 (set wins).
  - A new start does not clear DONE.
- irq: registered, equals DONE & IRQ_EN, updating one cycle after either changes.
- Reset mid-operation: rst dominates everything; a pending response is dropped and busy is cleared.
- Implementation: cfg is a generated register array; no latches; all outputs except icb_cmd_ready are registered.

Test Plan:
- Reset -> rsp_valid = 0; cfg all 0; ID read returns 32'hACC0_0002 with err = 0, rsp_valid exactly one cycle after the command.
- Write CFG[2] (offset 0x14) with 32'hFFFF_FFFF, wmask 4'b0101, after 0 -> readback 32'h00FF_00FF; other cfg unchanged.
- Write CTRL 32'h3 -> start high exactly one cycle; busy = 1. Second start -> err = 1 and no pulse. Then acc_done -> busy = 0, DONE = 1, irq = 1 one cycle later.
- W1C STATUS 32'h1 fired the same cycle as acc_done -> DONE stays 1. A later W1C alone -> DONE = 0, irq = 0.
- Read offset 0x0C+4*NUM_CFG, and read addr 0x02 -> err = 1, rdata = 0, no register changes.
- Hold rsp_ready = 0 for 5 cycles after a read -> cmd_ready = 0, response held stable. Then rsp_ready = 1 with a queued command -> accepted the same cycle, next response the following cycle.
